// File: rtl/mem_burst_pkg.sv
// Shared types and default widths for the burst loader.
// No logic; no latency.
// No backpressure; types only.
package mem_burst_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 9;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } state_t;

endpackage

// File: rtl/mem_burst_fifo.sv
// Small synchronous FIFO with pointer-based full/empty flags and a combinational head.
// Latency: a pushed word is visible on head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; the caller uses full/empty.
module mem_burst_fifo
  import mem_burst_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  // Pointers carry an extra wrap bit so equal indices can be told apart as full or empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    head     = mem_q[rd_ptr_q[PW-1:0]];
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/mem_burst_loader.sv
// Burst write loader: takes a command plus a beat stream and issues sequential memory writes.
// Latency: two cycles from an accepted beat to mem_w with an empty FIFO; one write per cycle sustained.
// Backpressure: beats stall on a full FIFO or once the burst count is reached; writes hold while mem_ready is low.
module mem_burst_loader
  import mem_burst_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int LW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          cmd_incr,
  input  logic          wvalid,
  output logic          wready,
  input  logic [DW-1:0] wdata,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [LW:0] CNT_ONE = {{LW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [LW:0]   total_q, total_d;
  logic [LW:0]   in_cnt_q, in_cnt_d;
  logic [LW:0]   out_cnt_q, out_cnt_d;
  logic          incr_q, incr_d;
  logic          mem_w_q, mem_w_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_data_q, mem_data_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic [DW-1:0] fifo_head;
  logic          fifo_full;
  logic          fifo_empty;

  mem_burst_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (fifo_push),
    .wdata  (wdata),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Next-state, handshakes and the registered write stage.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    total_d    = total_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    incr_d     = incr_q;
    mem_w_d    = mem_w_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cmd_ready  = 1'b0;
    wready     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          total_d    = {1'b0, cmd_len} + CNT_ONE;
          incr_d     = cmd_incr;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          state_d    = BURST;
        end
      end

      BURST: begin
        busy      = 1'b1;
        wready    = !fifo_full && (in_cnt_q != total_q);
        fifo_push = wvalid && wready;
        if (fifo_push) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
        end
        // The output register may reload whenever it is empty or its write is being taken.
        fifo_pop = !fifo_empty && (!mem_w_q || mem_ready);
        if (fifo_pop) begin
          mem_w_d    = 1'b1;
          mem_addr_d = cur_addr_q;
          mem_data_d = fifo_head;
          cur_addr_d = cur_addr_q + {{(AW-1){1'b0}}, incr_q};
          out_cnt_d  = out_cnt_q + CNT_ONE;
        end else if (mem_w_q && mem_ready) begin
          mem_w_d = 1'b0;
          if (out_cnt_q == total_q) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any write in flight.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      total_q    <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      incr_q     <= 1'b0;
      mem_w_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      total_q    <= total_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      incr_q     <= incr_d;
      mem_w_q    <= mem_w_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_w    = mem_w_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;

endmodule

// File: tb/tb_mem_burst_loader.sv
// Directed bench for the burst loader with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked there and logged on the falling edge.
// mem_ready is driven directly to create stalls.
module tb_mem_burst_loader;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int LW = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_incr;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic          busy;
  logic          done;

  mem_burst_loader #(
    .DW         (DW),
    .AW         (AW),
    .LW         (LW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_incr  (cmd_incr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .mem_w     (mem_w),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_base;
  bit abort = 1'b0;
  bit fdone = 1'b0;
  bit ftimeout = 1'b0;

  logic [AW-1:0] log_addr [$];
  logic [DW-1:0] log_data [$];
  int            log_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write the memory accepts at the coming edge, and count done cycles.
  always @(negedge clk) begin
    if (mem_w === 1'b1 && mem_ready === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_data);
      log_cyc.push_back(cyc);
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    done_base = done_cnt;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic inc);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_incr  = inc;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("busy_after_cmd", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic feed(input int n, input logic [DW-1:0] base);
    int i = 0;
    int g = 0;
    fdone = 1'b0;
    while (i < n && !abort && g < 300) begin
      wvalid = 1'b1;
      wdata  = base + DW'(i);
      if (wready) i++;
      step();
      g++;
    end
    wvalid   = 1'b0;
    ftimeout = (i < n) && !abort;
    fdone    = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_mem_w_low"}, mem_w, 0);
    step();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_done_count"}, done_cnt - done_base, 1);
    chk({tag, "_idle_ready"}, cmd_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask

  task automatic check_log(input string tag, input int n, input logic [AW-1:0] a0,
                           input logic inc, input logic [DW-1:0] dbase);
    logic [AW-1:0] ea;
    chk({tag, "_count"}, log_addr.size(), n);
    for (int i = 0; i < n && i < log_addr.size(); i++) begin
      ea = inc ? (a0 + AW'(i)) : a0;
      chk({tag, "_addr"}, log_addr[i], ea);
      chk({tag, "_data"}, log_data[i], dbase + DW'(i));
    end
  endtask

  initial begin
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    int k;

    nreset    = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_incr  = 1'b0;
    wvalid    = 1'b0;
    wdata     = '0;
    mem_ready = 1'b1;
    done_base = 0;
    #12;
    chk("rst_mem_w", mem_w, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wready", wready, 0);
    step();
    nreset = 1'b1;
    step();

    // Single beat with exact cycle timing.
    clear_log();
    send_cmd(9'h010, 8'd0, 1'b1);
    wvalid = 1'b1;
    wdata  = 32'hDEADBEEF;
    chk("single_wready", wready, 1);
    step();
    wvalid = 1'b0;
    chk("single_lat_k", mem_w, 0);
    step();
    chk("single_lat_k1", mem_w, 1);
    chk("single_addr", mem_addr, 9'h010);
    chk("single_data", mem_data, 32'hDEADBEEF);
    wait_done("single");
    check_log("single_log", 1, 9'h010, 1'b1, 32'hDEADBEEF);

    // Incrementing burst across the top of the address space.
    clear_log();
    send_cmd(9'h1FE, 8'd3, 1'b1);
    fork feed(4, 32'd1); join_none
    wait_done("wrap");
    chk("wrap_feed_ok", {fdone, ftimeout}, 2'b10);
    check_log("wrap_log", 4, 9'h1FE, 1'b1, 32'd1);
    for (int i = 1; i < 4 && i < log_cyc.size(); i++)
      chk("wrap_b2b", log_cyc[i] - log_cyc[i-1], 1);

    // Fixed-address burst.
    clear_log();
    send_cmd(9'h020, 8'd2, 1'b0);
    fork feed(3, 32'hA); join_none
    wait_done("fixed");
    chk("fixed_feed_ok", {fdone, ftimeout}, 2'b10);
    check_log("fixed_log", 3, 9'h020, 1'b0, 32'hA);

    // Eight beats with a three-cycle memory stall after the first write.
    clear_log();
    send_cmd(9'h100, 8'd7, 1'b1);
    fork feed(8, 32'hB0000000); join_none
    step();
    step();
    step();
    mem_ready = 1'b0;
    chk("bp_stall_mem_w", mem_w, 1);
    chk("bp_stall_log", log_addr.size(), 1);
    sa = mem_addr;
    sd = mem_data;
    chk("bp_stall_addr0", sa, 9'h101);
    chk("bp_stall_data0", sd, 32'hB0000001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_mem_w", mem_w, 1);
      chk("bp_hold_addr", mem_addr, sa);
      chk("bp_hold_data", mem_data, sd);
    end
    chk("bp_full_wready", wready, 0);
    mem_ready = 1'b1;
    wait_done("bp");
    chk("bp_feed_ok", {fdone, ftimeout}, 2'b10);
    check_log("bp_log", 8, 9'h100, 1'b1, 32'hB0000000);

    // Data offered before the command and beyond the burst length.
    clear_log();
    wvalid = 1'b1;
    wdata  = 32'hE0;
    chk("early_idle0", wready, 0);
    step();
    chk("early_idle1", wready, 0);
    cmd_addr  = 9'h030;
    cmd_len   = 8'd1;
    cmd_incr  = 1'b1;
    cmd_valid = 1'b1;
    chk("early_cmd_cycle", wready, 0);
    step();
    cmd_valid = 1'b0;
    chk("early_after_cmd", wready, 1);
    step();
    wdata = 32'hE1;
    chk("early_beat1", wready, 1);
    step();
    wdata = 32'hE2;
    chk("early_extra0", wready, 0);
    step();
    chk("early_extra1", wready, 0);
    wait_done("early");
    wvalid = 1'b0;
    check_log("early_log", 2, 9'h030, 1'b1, 32'hE0);

    // Reset after two of six writes, then a clean burst.
    clear_log();
    send_cmd(9'h040, 8'd5, 1'b1);
    abort = 1'b0;
    fork feed(6, 32'h60); join_none
    k = 0;
    while (log_addr.size() < 2 && k < 50) begin
      step();
      k++;
    end
    chk("rst_mid_two", log_addr.size(), 2);
    chk("rst_mid_mem_w_pre", mem_w, 1);
    nreset = 1'b0;
    #1;
    chk("rst_mid_mem_w", mem_w, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    abort = 1'b1;
    step();
    step();
    k = 0;
    while (!fdone && k < 10) begin
      step();
      k++;
    end
    chk("rst_mid_feed_stop", fdone, 1);
    chk("rst_mid_no_more", log_addr.size(), 2);
    nreset = 1'b1;
    abort  = 1'b0;
    step();
    chk("rst_rel_cmd_ready", cmd_ready, 1);
    chk("rst_rel_wready", wready, 0);
    clear_log();
    send_cmd(9'h050, 8'd2, 1'b1);
    fork feed(3, 32'h50); join_none
    wait_done("post");
    chk("post_feed_ok", {fdone, ftimeout}, 2'b10);
    check_log("post_log", 3, 9'h050, 1'b1, 32'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
